// File: rtl/chassis_pkg.sv
// Shared encodings for the chassis motion controller: direction codes,
// per-motor bridge states and controller FSM states.
package chassis_pkg;

  localparam int DIR_STOP  = 0;
  localparam int DIR_FWD   = 1;
  localparam int DIR_BACK  = 2;
  localparam int DIR_LEFT  = 3;
  localparam int DIR_RIGHT = 4;

  typedef enum logic [1:0] {
    MOT_OFF = 2'd0,
    MOT_FWD = 2'd1,
    MOT_REV = 2'd2
  } motor_state_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } fsm_state_e;

  // A direct FWD<->REV swap would shoot through the bridge; OFF transitions are safe.
  function automatic logic is_reversal(input motor_state_e cur, input motor_state_e tgt);
    return ((cur == MOT_FWD) && (tgt == MOT_REV)) ||
           ((cur == MOT_REV) && (tgt == MOT_FWD));
  endfunction

endpackage

// File: rtl/chassis_pwm_gen.sv
// Free-running PWM counter with duty compare; an all-ones speed means
// permanently on so full speed has no off slot in the period.
module chassis_pwm_gen #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PWM_WIDTH-1:0] speed,
  output logic                 pwm_on
);

  logic [PWM_WIDTH-1:0] cnt_q;
  logic [PWM_WIDTH-1:0] cnt_d;

  assign cnt_d = cnt_q + PWM_WIDTH'(1);

  // NOTE: registers are written with non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign pwm_on = (speed == '1) || (cnt_q < speed);

endmodule

// File: rtl/chassis_motion_ctrl.sv
// Chassis drive controller: decodes direction commands into per-motor H-bridge
// states, inserts a dead-time on reversal and gates the pins with PWM.
module chassis_motion_ctrl
  import chassis_pkg::*;
#(
  parameter int NUM_MOTORS      = 4,
  parameter int DIRECTION_WIDTH = 3,
  parameter int PWM_WIDTH       = 8,
  parameter int DEAD_CYCLES     = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  input  logic [DIRECTION_WIDTH-1:0] cmd_dir,
  input  logic [PWM_WIDTH-1:0]       cmd_speed,
  output logic                       cmd_ready,
  output logic [2*NUM_MOTORS-1:0]    dir_out,
  output logic                       busy
);

  localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

  fsm_state_e              state_q, state_d;
  logic [CNT_W-1:0]        dead_q, dead_d;
  logic [PWM_WIDTH-1:0]    speed_q, speed_d;
  motor_state_e            motor_q   [NUM_MOTORS];
  motor_state_e            motor_d   [NUM_MOTORS];
  motor_state_e            pending_q [NUM_MOTORS];
  motor_state_e            pending_d [NUM_MOTORS];
  motor_state_e            target    [NUM_MOTORS];
  logic [NUM_MOTORS-1:0]   reversing;
  logic [2*NUM_MOTORS-1:0] dir_q, dir_d;
  logic                    accept;
  logic                    pwm_on;

  assign cmd_ready = (state_q == ST_RUN) && !rst;
  assign busy      = (state_q == ST_DEAD);
  assign accept    = cmd_valid && cmd_ready;
  assign dir_out   = dir_q;

  chassis_pwm_gen #(.PWM_WIDTH(PWM_WIDTH)) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .speed  (speed_q),
    .pwm_on (pwm_on)
  );

  // Left spins the first half of the motors backward; right is the mirror image.
  always_comb begin : decode
    for (int m = 0; m < NUM_MOTORS; m++) begin
      case (cmd_dir)
        DIRECTION_WIDTH'(DIR_FWD):   target[m] = MOT_FWD;
        DIRECTION_WIDTH'(DIR_BACK):  target[m] = MOT_REV;
        DIRECTION_WIDTH'(DIR_LEFT):  target[m] = (m < NUM_MOTORS / 2) ? MOT_REV : MOT_FWD;
        DIRECTION_WIDTH'(DIR_RIGHT): target[m] = (m < NUM_MOTORS / 2) ? MOT_FWD : MOT_REV;
        default:                     target[m] = MOT_OFF;
      endcase
      reversing[m] = is_reversal(motor_q[m], target[m]);
    end
  end

  // NOTE: every signal driven here gets its hold value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin : next_state
    state_d   = state_q;
    dead_d    = dead_q;
    speed_d   = speed_q;
    motor_d   = motor_q;
    pending_d = pending_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          speed_d   = cmd_speed;
          pending_d = target;
          for (int m = 0; m < NUM_MOTORS; m++) begin
            motor_d[m] = reversing[m] ? MOT_OFF : target[m];
          end
          if (|reversing) begin
            state_d = ST_DEAD;
            dead_d  = DEAD_LOAD;
          end
        end
      end
      ST_DEAD: begin
        // Non-reversing motors already hold their pending target, so loading all is safe.
        if (dead_q == '0) begin
          motor_d = pending_q;
          state_d = ST_RUN;
        end else begin
          dead_d = dead_q - CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin : pin_map
    dir_d = '0;
    for (int m = 0; m < NUM_MOTORS; m++) begin
      dir_d[2*m]   = (motor_q[m] == MOT_FWD) && pwm_on;
      dir_d[2*m+1] = (motor_q[m] == MOT_REV) && pwm_on;
    end
  end

  // NOTE: the small motor/pending arrays are control state, not storage, so
  // they are reset; a reset mid dead-time must drop the pending targets.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      dead_q  <= '0;
      speed_q <= '0;
      dir_q   <= '0;
      for (int m = 0; m < NUM_MOTORS; m++) begin
        motor_q[m]   <= MOT_OFF;
        pending_q[m] <= MOT_OFF;
      end
    end else begin
      state_q   <= state_d;
      dead_q    <= dead_d;
      speed_q   <= speed_d;
      dir_q     <= dir_d;
      motor_q   <= motor_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_chassis_motion_ctrl.sv
// Self-checking bench for chassis_motion_ctrl with 4 motors, 4-bit PWM and a
// 4-cycle dead-time; per-cycle expectations flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_chassis_motion_ctrl;
  import chassis_pkg::*;

  localparam int NM = 4;
  localparam int DW = 3;
  localparam int PW = 4;
  localparam int DC = 4;
  localparam logic [PW-1:0] SPD_FULL = 4'd15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [DW-1:0] cmd_dir = '0;
  logic [PW-1:0] cmd_speed = '0;
  logic          cmd_ready;
  logic          busy;
  logic [2*NM-1:0] dir_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    bit         chk_dir;
    logic [7:0] dir;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  chassis_motion_ctrl #(
    .NUM_MOTORS(NM), .DIRECTION_WIDTH(DW), .PWM_WIDTH(PW), .DEAD_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_speed (cmd_speed),
    .cmd_ready (cmd_ready),
    .dir_out   (dir_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  // Monitor: pin-pair invariant every cycle, scoreboard pop when an expectation is queued.
  always @(negedge clk) begin
    for (int m = 0; m < NM; m++) begin
      checks++;
      if ((dir_out[2*m] & dir_out[2*m+1]) === 1'b1) begin
        errors++;
        $display("FAIL pin_overlap motor %0d at %0t: dir_out=%b, required pins not both 1", m, $time, dir_out);
      end
    end
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      if (e_mon.chk_dir) begin
        checks++;
        if (dir_out !== e_mon.dir) begin
          errors++;
          $display("FAIL %s dir_out at %0t: got %b expected %b", e_mon.name, $time, dir_out, e_mon.dir);
        end
      end
      checks++;
      if (busy !== e_mon.busy) begin
        errors++;
        $display("FAIL %s busy at %0t: got %b expected %b", e_mon.name, $time, busy, e_mon.busy);
      end
      checks++;
      if (cmd_ready !== e_mon.ready) begin
        errors++;
        $display("FAIL %s cmd_ready at %0t: got %b expected %b", e_mon.name, $time, cmd_ready, e_mon.ready);
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] s);
    cmd_valid = v;
    cmd_dir   = d;
    cmd_speed = s;
  endtask

  // Queue the expectation for the current cycle, let the monitor consume it,
  // then move to just after the next rising edge.
  task automatic tick_obs(input string name, input bit chk_dir, input logic [7:0] e_dir,
                          input logic e_busy, input logic e_ready, output logic [7:0] obs);
    exp_t e;
    e.name    = name;
    e.chk_dir = chk_dir;
    e.dir     = e_dir;
    e.busy    = e_busy;
    e.ready   = e_ready;
    sb.push_back(e);
    @(negedge clk);
    obs = dir_out;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input string name, input bit chk_dir, input logic [7:0] e_dir,
                      input logic e_busy, input logic e_ready);
    logic [7:0] unused_obs;
    tick_obs(name, chk_dir, e_dir, e_busy, e_ready, unused_obs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, DW'(DIR_FWD), SPD_FULL);
    @(posedge clk);
    #1;
    tick("reset_hold", 1, 8'h00, 1'b0, 1'b0);
    tick("reset_hold", 1, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, DW'(DIR_STOP), '0);
    tick("after_reset", 1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_forward_full();
    drive(1'b1, DW'(DIR_FWD), SPD_FULL);
    tick("fwd_accept", 1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_FWD), SPD_FULL);
    tick("fwd_lag", 1, 8'h00, 1'b0, 1'b1);
    repeat (6) tick("fwd_steady", 1, 8'h55, 1'b0, 1'b1);
  endtask

  // Forward -> backward, with a stop command held valid through the dead window.
  task automatic test_reversal();
    drive(1'b1, DW'(DIR_BACK), SPD_FULL);
    tick("rev_accept", 1, 8'h55, 1'b0, 1'b1);
    drive(1'b1, DW'(DIR_STOP), SPD_FULL);
    tick("rev_dead_lag", 1, 8'h55, 1'b1, 1'b0);
    repeat (3) tick("rev_dead", 1, 8'h00, 1'b1, 1'b0);
    tick("rev_run_first", 1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_STOP), SPD_FULL);
    tick("rev_target", 1, 8'hAA, 1'b0, 1'b1);
    repeat (3) tick("rev_held_stop", 1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_left();
    drive(1'b1, DW'(DIR_FWD), SPD_FULL);
    tick("left_pre_accept", 1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_FWD), SPD_FULL);
    tick("left_pre_lag", 1, 8'h00, 1'b0, 1'b1);
    tick("left_pre_steady", 1, 8'h55, 1'b0, 1'b1);
    drive(1'b1, DW'(DIR_LEFT), SPD_FULL);
    tick("left_accept", 1, 8'h55, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_LEFT), SPD_FULL);
    tick("left_dead_lag", 1, 8'h55, 1'b1, 1'b0);
    repeat (3) tick("left_dead", 1, 8'h50, 1'b1, 1'b0);
    tick("left_run_lag", 1, 8'h50, 1'b0, 1'b1);
    repeat (3) tick("left_final", 1, 8'h5A, 1'b0, 1'b1);
  endtask

  task automatic test_stop_back_invalid();
    drive(1'b1, DW'(DIR_STOP), SPD_FULL);
    tick("stop_accept", 1, 8'h5A, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_STOP), SPD_FULL);
    tick("stop_lag", 1, 8'h5A, 1'b0, 1'b1);
    tick("stop_off", 1, 8'h00, 1'b0, 1'b1);
    drive(1'b1, DW'(DIR_BACK), SPD_FULL);
    tick("back_accept", 1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_BACK), SPD_FULL);
    tick("back_no_dead", 1, 8'h00, 1'b0, 1'b1);
    repeat (3) tick("back_steady", 1, 8'hAA, 1'b0, 1'b1);
    drive(1'b1, 3'd7, SPD_FULL);
    tick("dir7_accept", 1, 8'hAA, 1'b0, 1'b1);
    drive(1'b0, 3'd7, SPD_FULL);
    tick("dir7_lag", 1, 8'hAA, 1'b0, 1'b1);
    repeat (3) tick("dir7_off", 1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_pwm();
    logic [7:0] obs;
    int fwd_cnt [NM];
    int rev_cnt [NM];
    drive(1'b1, DW'(DIR_FWD), 4'd4);
    tick("pwm4_accept", 1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_FWD), 4'd4);
    tick("pwm4_lag", 1, 8'h00, 1'b0, 1'b1);
    for (int m = 0; m < NM; m++) begin
      fwd_cnt[m] = 0;
      rev_cnt[m] = 0;
    end
    for (int c = 0; c < 16; c++) begin
      tick_obs("pwm4_run", 0, 8'h00, 1'b0, 1'b1, obs);
      for (int m = 0; m < NM; m++) begin
        fwd_cnt[m] += int'(obs[2*m]);
        rev_cnt[m] += int'(obs[2*m+1]);
      end
    end
    for (int m = 0; m < NM; m++) begin
      checks++;
      if (fwd_cnt[m] !== 4) begin
        errors++;
        $display("FAIL pwm4_duty motor %0d: high %0d of 16 cycles, expected 4", m, fwd_cnt[m]);
      end
      checks++;
      if (rev_cnt[m] !== 0) begin
        errors++;
        $display("FAIL pwm4_rev_pin motor %0d: high %0d of 16 cycles, expected 0", m, rev_cnt[m]);
      end
    end
    // Speed 0 on the same direction: no reversal, output fully off from two cycles on.
    drive(1'b1, DW'(DIR_FWD), 4'd0);
    tick("pwm0_accept", 0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_FWD), 4'd0);
    tick("pwm0_lag", 0, 8'h00, 1'b0, 1'b1);
    repeat (18) tick("pwm0_off", 1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_dead();
    drive(1'b1, DW'(DIR_FWD), SPD_FULL);
    tick("rmd_fwd_accept", 1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_FWD), SPD_FULL);
    tick("rmd_fwd_lag", 1, 8'h00, 1'b0, 1'b1);
    tick("rmd_fwd_steady", 1, 8'h55, 1'b0, 1'b1);
    drive(1'b1, DW'(DIR_BACK), SPD_FULL);
    tick("rmd_back_accept", 1, 8'h55, 1'b0, 1'b1);
    drive(1'b0, DW'(DIR_BACK), SPD_FULL);
    rst = 1'b1;
    tick("rmd_rst_cycle", 1, 8'h55, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (8) tick("rmd_cleared", 1, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_forward_full();
    test_reversal();
    test_left();
    test_stop_back_invalid();
    test_pwm();
    test_reset_mid_dead();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chassis_motion_ctrl.md
# chassis_motion_ctrl

Parametrised chassis drive controller: accepts direction/speed commands over a valid/ready handshake and drives an H-bridge pin pair per motor. Generalises the fixed 4-motor decoder to `NUM_MOTORS` motors. Adds PWM speed gating and a reversal dead-time so no bridge ever switches directly between forward and reverse. Sits between the command/decrypt path and the motor driver pins.

## Interface
- `NUM_MOTORS`, 4: motor count; must be even and ≥2.
- `DIRECTION_WIDTH`, 3: width of the direction code.
- `PWM_WIDTH`, 8: PWM counter and speed width.
- `DEAD_CYCLES`, 1000: cycles a reversing motor is held off; must be ≥1.

- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_dir`  in  DIRECTION_WIDTH: 0 stop, 1 forward, 2 backward, 3 left, 4 right, others treated as stop.
- `cmd_speed`  in  PWM_WIDTH: duty setting.
- `cmd_ready`  out  1: command can be accepted this cycle.
- `dir_out`  out  2*NUM_MOTORS: `dir_out[2m]` is the forward pin of motor m, `dir_out[2m+1]` is its reverse pin.
- `busy`  out  1: dead-time in progress.

## Operation
- Per-motor state is one of OFF, FWD, REV. Targets by direction:
  - stop/invalid: all OFF.
  - forward: all FWD.
  - backward: all REV.
  - left: motors 0..NUM_MOTORS/2-1 REV, the rest FWD.
  - right: the inverse of left.
- A command is accepted on a rising edge when `cmd_valid & cmd_ready`. The speed register loads on acceptance.
- FSM states:
  - RUN: `cmd_ready`=1. On acceptance, a motor is *reversing* if its current state is FWD and its target is REV, or vice versa.
    - If no motor is reversing: all motor states load their targets and the FSM stays in RUN.
    - If any motor is reversing: non-reversing motors load their targets immediately, reversing motors go to OFF, the targets are stored as pending, the dead counter loads DEAD_CYCLES-1, and the FSM goes to DEAD.
  - DEAD: `cmd_ready`=0, `busy`=1, and the counter decrements each cycle. When the counter is 0, the next edge loads the pending targets into the reversing motors and returns to RUN.
- Reversal is judged only against the current state. A change from OFF to FWD or REV gets no dead-time.
- PWM: a free-running `PWM_WIDTH`-bit counter wraps from all-ones to 0 and runs in every state.
  - `pwm_on` = (cnt < speed), except that speed = all-ones forces `pwm_on`=1.
  - speed = 0 gives an output that is always off.
- Output: the pin pair for motor m is registered as FWD → {rev=0, fwd=pwm_on}, REV → {rev=pwm_on, fwd=0}, OFF → 00.
- Invariant: `dir_out[2m]` and `dir_out[2m+1]` are never both 1.

## Timing
- Reset values:
  - `dir_out`=0, `busy`=0.
  - Motors OFF, speed=0, PWM counter=0, dead counter=0, FSM in RUN.
  - `cmd_ready` is forced to 0 while `rst` is high.
- Latency without reversal: for a command accepted at edge k, the motor state updates at edge k and `dir_out` reflects it after edge k+1.
- Reversal: a reversing motor's state is OFF from edge k through edge k+DEAD_CYCLES-1 and loads its new target at edge k+DEAD_CYCLES. `dir_out` lags the state by one cycle. `busy` is high for exactly DEAD_CYCLES cycles.
- `cmd_ready`/`busy` are decoded from the registered state. A command held during DEAD is accepted on the first RUN cycle.
- Reset during DEAD aborts the dead-time and discards the pending targets. Everything is off on the next cycle.
- Speed changes take effect at the PWM compare on the cycle after acceptance, with no wait for the PWM period boundary.

## Structure
- Shared package `chassis_pkg`:
  - direction code constants (DIR_STOP=0, DIR_FWD=1, DIR_BACK=2, DIR_LEFT=3, DIR_RIGHT=4);
  - motor state encoding (OFF/FWD/REV);
  - FSM state encoding (RUN/DEAD).
- Sub-module `chassis_pwm_gen`: PWM counter plus compare, with the all-ones full-on rule. Outputs `pwm_on`.
- The direction decode, reversal detect, FSM and output registers stay in the top module.

## Test plan
All scenarios use bench parameters NUM_MOTORS=4, PWM_WIDTH=4, DEAD_CYCLES=4.
- Reset, then issue forward with speed 15 → `dir_out`=8'b01010101 two cycles after acceptance, constant. `cmd_ready`=0 while `rst`=1.
- Forward at speed 4 → each forward pin is high for exactly 4 of every 16 cycles. Speed 0 → `dir_out`=0 throughout.
- Forward at speed 15, then backward → `busy` high for 4 cycles, `dir_out`=0 during the dead window, then 8'b10101010. `cmd_ready`=0 throughout, and a command held valid meanwhile is accepted on the first cycle after `busy` falls.
- Forward then left → motors 2,3 stay 01 with no gap, motors 0,1 are 00 for 4 cycles then 10.
- Stop, then backward → no dead-time, `busy` stays 0. Direction code 7 → all outputs 0.
- Assert `rst` mid-dead-time → `dir_out`=0 and `busy`=0 the next cycle, and the pending target is never applied. A checker asserts no motor ever has both of its pins high in any cycle.
